biu_param: RTL and testbench
============================

Name: biu_param

Overview:
- Parametrised successor to the single-byte bus interface unit.
- Single-port, word-addressed local memory behind a valid/ready request channel and a valid/ready response channel.
- Adds configurable data/address width and memory depth, byte-lane write enables, programmable wait states, out-of-range error response, and response back-pressure.
- Sits between a core-side bus master and on-chip scratch memory.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, word-address width.
- DEPTH, 1024, number of implemented words; must be <= 2**ADDR_W.
- WAIT_CYCLES, 1, extra access cycles inserted before each response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; ignored for reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  master accepts the response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address >= DEPTH.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at a rising edge: latch write, addr, wdata and be; load counter=WAIT_CYCLES; go to ACCESS.
  - req_ready is combinational from the state only, never from req_valid.
- ACCESS:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0, perform the memory operation at that edge and go to RESP.
  - With WAIT_CYCLES=0, ACCESS lasts exactly 1 cycle.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
- Memory operation rules:
  - Write: each lane i with be[i]=1 updates bits [8i+7:8i]; all other lanes are unchanged.
  - Write with be all-zero: no memory change, normal response.
  - Read: resp_rdata = mem[addr] as of the commit edge.
  - addr >= DEPTH: no memory access; resp_err=1; resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On handshake: go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - resp_ready high on entry to RESP gives a single response cycle.
- Throughput: at most one outstanding transaction; minimum period WAIT_CYCLES+3 cycles per transaction.
- Request stability: req_* changes while req_ready=0 are ignored, because the latched copy is used.
- Reset mid-operation: asserting reset in ACCESS before the commit edge aborts the request with no memory write. In RESP, reset drops the pending response. Outputs return to reset values asynchronously.
- Read after write to the same address: returns the new data.

Optional Feature:
- Macro: BIU_STATS_EN.
- When defined, adds ports:
  - stat_rd_cnt  out  16  reads completed.
  - stat_wr_cnt  out  16  writes completed.
  - stat_err_cnt  out  16  error responses.
  - stat_clr  in  1  synchronous clear of all counters.
- Counting rules:
  - Counters increment on the response handshake edge.
  - Counters saturate at 0xFFFF.
  - stat_clr has priority over increment.
  - Counters reset to 0.
  - Error responses increment stat_err_cnt only.
- When not defined: the ports and counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package biu_pkg: FSM state enum biu_state_t (IDLE, ACCESS, RESP) and localparam STAT_W=16.
- One sub-module, biu_mem_bank: a DEPTH x DATA_W single-port synchronous RAM with per-byte write enables, keeping the memory inferable.
- FSM, counter and stats stay in biu_param.

Test Plan:
- Reset, then check reset values. Write addr 5, data 0xDEADBEEF, be 4'hF. Read addr 5 -> resp_rdata=0xDEADBEEF, resp_err=0; with WAIT_CYCLES=1, resp_valid rises 2 cycles after the accept edge.
- Byte enables: write 0x11223344 be=4'b0101 over 0xAAAAAAAA at addr 7. Read -> 0xAA22AA44.
- Out of range (DEPTH=1000): read addr 1000 -> resp_err=1, rdata=0. Write addr 1023 -> resp_err=1, and memory is unchanged.
- Back-pressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable and req_ready=0 throughout. Release -> IDLE next cycle with req_ready=1.
- Reset mid-ACCESS (WAIT_CYCLES=3): write 0x12345678 to addr 2 (prior value 0), reset 1 cycle after accept. Read addr 2 -> 0x00000000; no response was issued for the aborted write.
- BIU_STATS_EN: run 3 reads, 2 writes, 1 error -> counters read 3/2/1. Pulse stat_clr -> all counters 0.

Source files
------------

// File: rtl/biu_pkg.sv
// Shared definitions for the parametrised bus interface unit: FSM state
// encoding and the width of the optional statistics counters.
package biu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } biu_state_t;

   localparam int STAT_W = 16;

endpackage

// File: rtl/biu_mem_bank.sv
// Single-port synchronous scratch RAM, DEPTH words of DATA_W bits, with
// per-byte write enables. Reads are registered, so the read data is
// presented on rdata after the enabled edge. Contents are never reset,
// so the array stays inferable as block RAM.
module biu_mem_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   rdata
);

   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // One access per enabled edge: byte-masked write, or registered read
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < LANES; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/biu_param.sv
// Parametrised bus interface unit: one valid/ready request channel and one
// valid/ready response channel in front of a local word-addressed RAM.
// Each accepted request is latched, waits WAIT_CYCLES extra cycles, commits
// to memory, and is answered once; addresses at or beyond DEPTH get an
// error response without touching memory.
// Optional feature macro: BIU_STATS_EN adds saturating read/write/error
// counters with a synchronous clear.
module biu_param
   import biu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err
`ifdef BIU_STATS_EN
   ,
   input  logic                stat_clr,
   output logic [STAT_W-1:0]   stat_rd_cnt,
   output logic [STAT_W-1:0]   stat_wr_cnt,
   output logic [STAT_W-1:0]   stat_err_cnt
`endif
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

   biu_state_t state;
   biu_state_t state_nxt;

   logic [3:0]          cnt;
   logic                lat_write;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W/8-1:0] lat_be;

   logic                rd_flag;
   logic                err_q;
   logic [DATA_W-1:0]   bank_rdata;

   logic                accept;
   logic                commit;
   logic                in_range;
   logic                mem_en;
   logic                handshake;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign commit     = (state == ACCESS) && (cnt == 4'd0);
   assign in_range   = ({1'b0, lat_addr} < DEPTH_L);
   assign mem_en     = commit && in_range;
   assign handshake  = (state == RESP) && resp_ready;

   // Read data is only exposed while a read response is pending, so writes,
   // errors and the idle/reset state all present zero
   assign resp_rdata = rd_flag ? bank_rdata : '0;
   assign resp_err   = err_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept, count down the wait, then hold the response
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)       state_nxt = ACCESS;
         ACCESS:  if (cnt == 4'd0)  state_nxt = RESP;
         RESP:    if (resp_ready)   state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // Latch the request on accept so later changes on req_* are ignored,
   // and run the wait counter down while in ACCESS
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else if (accept) begin
         cnt       <= WAIT_L;
         lat_write <= req_write;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_be    <= req_be;
      end else if ((state == ACCESS) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Response flags set at the commit edge and cleared on the handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_flag <= 1'b0;
         err_q   <= 1'b0;
      end else if (commit) begin
         rd_flag <= !lat_write && in_range;
         err_q   <= !in_range;
      end else if (handshake) begin
         rd_flag <= 1'b0;
         err_q   <= 1'b0;
      end
   end

   biu_mem_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_bank (
      .clk   (clk),
      .en    (mem_en),
      .we    (lat_write),
      .addr  (lat_addr),
      .wdata (lat_wdata),
      .be    (lat_be),
      .rdata (bank_rdata)
   );

`ifdef BIU_STATS_EN
   // Saturating transaction counters bumped on the response handshake;
   // clear wins over increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_rd_cnt  <= '0;
         stat_wr_cnt  <= '0;
         stat_err_cnt <= '0;
      end else if (stat_clr) begin
         stat_rd_cnt  <= '0;
         stat_wr_cnt  <= '0;
         stat_err_cnt <= '0;
      end else if (handshake) begin
         if (err_q) begin
            if (stat_err_cnt != '1) stat_err_cnt <= stat_err_cnt + 1'b1;
         end else if (lat_write) begin
            if (stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1'b1;
         end else begin
            if (stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_biu_param.sv
// Self-checking bench for biu_param (DEPTH=1000, WAIT_CYCLES=1).
// A transaction-level model predicts every response; a negedge compare
// process checks the outputs each cycle, and directed scenarios pin the
// model with literal expectations. Build with BIU_STATS_EN to also check
// the statistics counters.
module tb_biu_param;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 10;
   localparam int DEPTH       = 1000;
   localparam int WAIT_CYCLES = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
`ifdef BIU_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_rd_cnt;
   logic [15:0] stat_wr_cnt;
   logic [15:0] stat_err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Transaction-level model state
   logic [31:0] model_mem [0:1023];
   bit          pending = 1'b0;
   bit          committed = 1'b0;
   int          wait_left = 0;
   logic        m_write;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] exp_rdata;
   logic        exp_err;

   // Values captured by the driver from the last completed transaction
   logic [31:0] got_rdata;
   logic        got_err;
   int          got_lat;

   biu_param #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
`ifdef BIU_STATS_EN
      ,
      .stat_clr     (stat_clr),
      .stat_rd_cnt  (stat_rd_cnt),
      .stat_wr_cnt  (stat_wr_cnt),
      .stat_err_cnt (stat_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Work out the response of the latched transaction and update model memory
   task automatic modelCommit();
      if (m_addr >= 10'(DEPTH)) begin
         exp_err   = 1'b1;
         exp_rdata = 32'h0;
      end else if (m_write) begin
         exp_err   = 1'b0;
         exp_rdata = 32'h0;
         for (int i = 0; i < 4; i++) begin
            if (m_be[i]) model_mem[m_addr][8*i +: 8] = m_wdata[8*i +: 8];
         end
      end else begin
         exp_err   = 1'b0;
         exp_rdata = model_mem[m_addr];
      end
   endtask

   // Per-cycle compare against the model; inputs sampled here decide what
   // happens at the following rising edge
   always @(negedge clk) begin
      if (reset) begin
         pending = 1'b0;
         checkOutput("rst_req_ready",  32'(req_ready),  32'd1);
         checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
         checkOutput("rst_resp_rdata", resp_rdata,      32'd0);
         checkOutput("rst_resp_err",   32'(resp_err),   32'd0);
      end else if (!pending) begin
         checkOutput("idle_req_ready",  32'(req_ready),  32'd1);
         checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
         checkOutput("idle_resp_rdata", resp_rdata,      32'd0);
         checkOutput("idle_resp_err",   32'(resp_err),   32'd0);
         if (req_valid) begin
            pending   = 1'b1;
            committed = 1'b0;
            wait_left = WAIT_CYCLES + 1;
            m_write   = req_write;
            m_addr    = req_addr;
            m_wdata   = req_wdata;
            m_be      = req_be;
         end
      end else if (wait_left > 0) begin
         checkOutput("busy_req_ready",  32'(req_ready),  32'd0);
         checkOutput("busy_resp_valid", 32'(resp_valid), 32'd0);
         wait_left--;
      end else begin
         if (!committed) begin
            modelCommit();
            committed = 1'b1;
         end
         checkOutput("resp_req_ready",  32'(req_ready),  32'd0);
         checkOutput("resp_resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("resp_rdata",      resp_rdata,      exp_rdata);
         checkOutput("resp_err",        32'(resp_err),   32'(exp_err));
         if (resp_ready) pending = 1'b0;
      end
   end

   // Issue one request, scramble req_* after accept, and complete the
   // response after holding resp_ready low for 'hold' response cycles
   task automatic applyStimulus(input logic w, input logic [9:0] a, input logic [31:0] d,
                                input logic [3:0] b, input int hold);
      bit acc;
      int n;
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      req_be     = b;
      resp_ready = (hold == 0);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got req_ready 0, expected 1 within 50 cycles");
      end
      req_valid = 1'b0;
      req_write = ~w;
      req_addr  = ~a;
      req_wdata = ~d;
      req_be    = ~b;
      got_lat = 0;
      while (!resp_valid && got_lat < 50) begin
         @(posedge clk);
         #1;
         got_lat++;
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
      end
      got_rdata  = resp_rdata;
      got_err    = resp_err;
      resp_ready = 1'b1;
      n = 0;
      while (resp_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (resp_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL resp_timeout: got resp_valid 1, expected 0 after handshake");
      end
      resp_ready = 1'b0;
   endtask

   // Accept a request, then assert reset one cycle later, before the commit edge
   task automatic resetMidAccess(input logic [9:0] a, input logic [31:0] d);
      bit acc;
      int n;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_be    = 4'hF;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_pre_valid", 32'(resp_valid), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req_ready",  32'(req_ready),  32'd1);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Full-word write then read back, with latency check
      applyStimulus(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 0);
      checkOutput("wr5_err", 32'(got_err), 32'd0);
      checkOutput("wr5_rdata", got_rdata, 32'd0);
      applyStimulus(1'b0, 10'd5, 32'h0, 4'h0, 0);
      checkOutput("rd5_rdata", got_rdata, 32'hDEADBEEF);
      checkOutput("rd5_err", 32'(got_err), 32'd0);
      checkOutput("rd5_latency", 32'(got_lat), 32'd2);

      // Byte-lane merge
      applyStimulus(1'b1, 10'd7, 32'hAAAAAAAA, 4'hF, 0);
      applyStimulus(1'b1, 10'd7, 32'h11223344, 4'b0101, 0);
      applyStimulus(1'b0, 10'd7, 32'h0, 4'h0, 0);
      checkOutput("rd7_merge", got_rdata, 32'hAA22AA44);

      // Out of range
      applyStimulus(1'b0, 10'd1000, 32'h0, 4'h0, 0);
      checkOutput("rd1000_err", 32'(got_err), 32'd1);
      checkOutput("rd1000_rdata", got_rdata, 32'd0);
      applyStimulus(1'b1, 10'd1023, 32'hCAFEF00D, 4'hF, 0);
      checkOutput("wr1023_err", 32'(got_err), 32'd1);
      applyStimulus(1'b0, 10'd999, 32'h0, 4'h0, 0);
      applyStimulus(1'b0, 10'd5, 32'h0, 4'h0, 0);
      checkOutput("rd5_after_oor", got_rdata, 32'hDEADBEEF);

      // Write with no lanes enabled leaves memory alone
      applyStimulus(1'b1, 10'd5, 32'h01020304, 4'h0, 0);
      checkOutput("wr5_be0_err", 32'(got_err), 32'd0);

      // Back-pressure: response held for 5 extra cycles
      applyStimulus(1'b0, 10'd5, 32'h0, 4'h0, 5);
      checkOutput("rd5_bp_rdata", got_rdata, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;

      // Reset during ACCESS aborts the write
      applyStimulus(1'b1, 10'd2, 32'h00000000, 4'hF, 0);
      resetMidAccess(10'd2, 32'h12345678);
      applyStimulus(1'b0, 10'd2, 32'h0, 4'h0, 0);
      checkOutput("rd2_after_abort", got_rdata, 32'h00000000);

`ifdef BIU_STATS_EN
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      applyStimulus(1'b0, 10'd5, 32'h0, 4'h0, 0);
      applyStimulus(1'b0, 10'd7, 32'h0, 4'h0, 0);
      applyStimulus(1'b0, 10'd2, 32'h0, 4'h0, 0);
      applyStimulus(1'b1, 10'd9, 32'h55555555, 4'hF, 0);
      applyStimulus(1'b1, 10'd10, 32'h66666666, 4'h3, 0);
      applyStimulus(1'b0, 10'd1001, 32'h0, 4'h0, 0);
      checkOutput("stat_rd", 32'(stat_rd_cnt), 32'd3);
      checkOutput("stat_wr", 32'(stat_wr_cnt), 32'd2);
      checkOutput("stat_err", 32'(stat_err_cnt), 32'd1);
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      checkOutput("stat_rd_clr", 32'(stat_rd_cnt), 32'd0);
      checkOutput("stat_wr_clr", 32'(stat_wr_cnt), 32'd0);
      checkOutput("stat_err_clr", 32'(stat_err_cnt), 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
